// File: rtl/tff_count_sequencer.sv
// rtl/tff_count_sequencer.sv - run/pause/stop sequencer driving a toggle-flop bank as a bounded counter
// Count advances by XOR with the toggle mask T; the terminal check always precedes any toggle.
module tff_count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Down,
   input  logic [WIDTH-1:0] Limit,
   output logic [WIDTH-1:0] T,
   output logic [WIDTH-1:0] Count,
   output logic             Busy,
   output logic             Done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] up_mask;
   logic [WIDTH-1:0] dn_mask;
   logic [WIDTH-1:0] terminal;
   logic             at_term;
   logic             launch;

   // Ripple-AND carry chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      up_mask    = '0;
      dn_mask    = '0;
      up_mask[0] = 1'b1;
      dn_mask[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         up_mask[i] = up_mask[i-1] & count_q[i-1];
         dn_mask[i] = dn_mask[i-1] & ~count_q[i-1];
      end
   end

   assign terminal = dir_q ? '0 : lim_q;
   assign at_term  = (count_q == terminal);
   assign launch   = (state_q == S_IDLE) && Start && !Stop;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (Start && !Stop) state_d = S_RUN;
         end
         S_RUN: begin
            if (at_term)   state_d = S_DONE;
            else if (Stop) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (Stop)       state_d = S_IDLE;
            else if (Start) state_d = S_RUN;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      T       = '0;
      dir_d   = dir_q;
      lim_d   = lim_q;
      count_d = count_q;
      if (state_q == S_RUN && !at_term && !Stop) begin
         T = dir_q ? dn_mask : up_mask;
      end
      if (launch) begin
         dir_d   = Down;
         lim_d   = Limit;
         count_d = Down ? Limit : '0;
      end else begin
         count_d = count_q ^ T;
      end
      busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
         lim_q   <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         lim_q   <= lim_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Count = count_q;
   assign Busy  = busy_q;
   assign Done  = done_q;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb/tb_tff_count_sequencer.sv - directed scenario bench for tff_count_sequencer
module tb_tff_count_sequencer;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic       Stop;
   logic       Down;
   logic [3:0] Limit;
   logic [3:0] T;
   logic [3:0] Count;
   logic       Busy;
   logic       Done;

   int errors;
   int checks;

   // Expected T indexed by the current Count value; entry at the terminal value is 0.
   logic [3:0] t_up [0:9]  = '{4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001,
                               4'b0011, 4'b0001, 4'b1111, 4'b0001, 4'b0000};
   logic [3:0] t_dn [0:15] = '{4'b0000, 4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001,
                               4'b0011, 4'b0001, 4'b1111, 4'b0001, 4'b0011, 4'b0001,
                               4'b0111, 4'b0001, 4'b0011, 4'b0001};

   tff_count_sequencer #(.WIDTH(4)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .Stop  (Stop),
      .Down  (Down),
      .Limit (Limit),
      .T     (T),
      .Count (Count),
      .Busy  (Busy),
      .Done  (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_cmd(input logic dn, input logic [3:0] lim);
      Start = 1'b1; Down = dn; Limit = lim;
      step();
      Start = 1'b0; Down = 1'b0; Limit = 4'd0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Down = 1'b0; Limit = 4'd0;
      step(); step();
      checks++; if (Count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", Count); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", Done); end
      checks++; if (T !== 4'd0) begin errors++; $display("FAIL reset_t got=%b exp=0000", T); end
      Reset = 1'b0;
      step(); step();
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%0b exp=0", Busy); end
   endtask

   task automatic test_up_count();
      start_cmd(1'b0, 4'd9);
      checks++; if (Count !== 4'd0) begin errors++; $display("FAIL up_load got=%0d exp=0", Count); end
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL up_busy got=%0b exp=1", Busy); end
      checks++; if (T !== 4'b0001) begin errors++; $display("FAIL up_t0 got=%b exp=0001", T); end
      for (int k = 1; k <= 9; k++) begin
         step();
         checks++; if (Count !== k[3:0]) begin errors++; $display("FAIL up_count k=%0d got=%0d exp=%0d", k, Count, k); end
         checks++; if (T !== t_up[k]) begin errors++; $display("FAIL up_t k=%0d got=%b exp=%b", k, T, t_up[k]); end
         checks++; if (Done !== 1'b0) begin errors++; $display("FAIL up_early_done k=%0d got=%0b exp=0", k, Done); end
      end
      step();
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL up_done got=%0b exp=1", Done); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL up_busy_fall got=%0b exp=0", Busy); end
      checks++; if (T !== 4'd0) begin errors++; $display("FAIL up_done_t got=%b exp=0000", T); end
      step();
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL up_done_once got=%0b exp=0", Done); end
      checks++; if (Count !== 4'd9) begin errors++; $display("FAIL up_hold got=%0d exp=9", Count); end
   endtask

   task automatic test_down_count();
      start_cmd(1'b1, 4'd15);
      checks++; if (Count !== 4'd15) begin errors++; $display("FAIL dn_load got=%0d exp=15", Count); end
      checks++; if (T !== 4'b0001) begin errors++; $display("FAIL dn_t0 got=%b exp=0001", T); end
      for (int k = 1; k <= 15; k++) begin
         step();
         checks++; if (Count !== 4'(15 - k)) begin errors++; $display("FAIL dn_count k=%0d got=%0d exp=%0d", k, Count, 15 - k); end
         checks++; if (T !== t_dn[15 - k]) begin errors++; $display("FAIL dn_t k=%0d got=%b exp=%b", k, T, t_dn[15 - k]); end
         checks++; if (Done !== 1'b0) begin errors++; $display("FAIL dn_early_done k=%0d got=%0b exp=0", k, Done); end
      end
      step();
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL dn_done got=%0b exp=1", Done); end
      checks++; if (Count !== 4'd0) begin errors++; $display("FAIL dn_nowrap got=%0d exp=0", Count); end
      step();
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL dn_done_once got=%0b exp=0", Done); end
      checks++; if (Count !== 4'd0) begin errors++; $display("FAIL dn_hold got=%0d exp=0", Count); end
   endtask

   task automatic test_pause_resume();
      start_cmd(1'b0, 4'd6);
      step(); step(); step();
      checks++; if (Count !== 4'd3) begin errors++; $display("FAIL pr_pre got=%0d exp=3", Count); end
      Stop = 1'b1;
      #1;
      checks++; if (T !== 4'd0) begin errors++; $display("FAIL pr_stop_t got=%b exp=0000", T); end
      step();
      Stop = 1'b0;
      checks++; if (Count !== 4'd3) begin errors++; $display("FAIL pr_frozen1 got=%0d exp=3", Count); end
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL pr_busy got=%0b exp=1", Busy); end
      checks++; if (T !== 4'd0) begin errors++; $display("FAIL pr_t1 got=%b exp=0000", T); end
      step();
      checks++; if (Count !== 4'd3) begin errors++; $display("FAIL pr_frozen2 got=%0d exp=3", Count); end
      checks++; if (T !== 4'd0) begin errors++; $display("FAIL pr_t2 got=%b exp=0000", T); end
      Start = 1'b1; Down = 1'b1; Limit = 4'd1;
      step();
      Start = 1'b0; Down = 1'b0; Limit = 4'd0;
      checks++; if (Count !== 4'd3) begin errors++; $display("FAIL pr_resume got=%0d exp=3", Count); end
      checks++; if (T !== 4'b0111) begin errors++; $display("FAIL pr_resume_t got=%b exp=0111", T); end
      for (int k = 4; k <= 6; k++) begin
         step();
         checks++; if (Count !== k[3:0]) begin errors++; $display("FAIL pr_count k=%0d got=%0d exp=%0d", k, Count, k); end
         checks++; if (Done !== 1'b0) begin errors++; $display("FAIL pr_early_done k=%0d got=%0b exp=0", k, Done); end
      end
      step();
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL pr_done got=%0b exp=1", Done); end
      step();
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL pr_done_once got=%0b exp=0", Done); end
      checks++; if (Count !== 4'd6) begin errors++; $display("FAIL pr_hold got=%0d exp=6", Count); end
   endtask

   task automatic test_abort_conflict();
      Start = 1'b1; Stop = 1'b1; Limit = 4'd5;
      step();
      Start = 1'b0; Stop = 1'b0; Limit = 4'd0;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL conflict_busy got=%0b exp=0", Busy); end
      checks++; if (Count !== 4'd6) begin errors++; $display("FAIL conflict_count got=%0d exp=6", Count); end
      start_cmd(1'b0, 4'd6);
      step();
      checks++; if (Count !== 4'd1) begin errors++; $display("FAIL abort_pre got=%0d exp=1", Count); end
      Stop = 1'b1;
      step();
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_paused got=%0b exp=1", Busy); end
      Start = 1'b1;
      step();
      Start = 1'b0; Stop = 1'b0;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b exp=0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done got=%0b exp=0", Done); end
      checks++; if (Count !== 4'd1) begin errors++; $display("FAIL abort_count got=%0d exp=1", Count); end
      step();
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done2 got=%0b exp=0", Done); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%0b exp=0", Busy); end
   endtask

   task automatic test_limit_zero();
      start_cmd(1'b0, 4'd0);
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL lz_busy got=%0b exp=1", Busy); end
      checks++; if (T !== 4'd0) begin errors++; $display("FAIL lz_t got=%b exp=0000", T); end
      checks++; if (Count !== 4'd0) begin errors++; $display("FAIL lz_count got=%0d exp=0", Count); end
      step();
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL lz_done got=%0b exp=1", Done); end
      checks++; if (Count !== 4'd0) begin errors++; $display("FAIL lz_count2 got=%0d exp=0", Count); end
      step();
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL lz_done_once got=%0b exp=0", Done); end
   endtask

   task automatic test_reset_mid_run();
      start_cmd(1'b0, 4'd9);
      step(); step(); step(); step(); step();
      checks++; if (Count !== 4'd5) begin errors++; $display("FAIL mr_pre got=%0d exp=5", Count); end
      #3;
      Reset = 1'b1;
      #1;
      checks++; if (Count !== 4'd0) begin errors++; $display("FAIL mr_count got=%0d exp=0", Count); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mr_busy got=%0b exp=0", Busy); end
      checks++; if (T !== 4'd0) begin errors++; $display("FAIL mr_t got=%b exp=0000", T); end
      step();
      Reset = 1'b0;
      step(); step();
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mr_idle got=%0b exp=0", Busy); end
      checks++; if (Count !== 4'd0) begin errors++; $display("FAIL mr_hold got=%0d exp=0", Count); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_up_count();
      test_down_count();
      test_pause_resume();
      test_abort_conflict();
      test_limit_zero();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tff_count_sequencer.md
# tff_count_sequencer

Run/pause/stop controller that drives a WIDTH-bit bank of toggle flip-flops as a bounded up or down counter. It computes the per-bit toggle-enable vector each cycle, applies it to an internal toggle register, and reports progress and completion. It sits between a host that issues Start/Stop commands and any logic that consumes the count value or the toggle enables, such as a downstream T-flip-flop bank kept in lockstep.

## Interface
- WIDTH, 4, counter/toggle-bank width in bits (≥2)
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; clears all state immediately
- Start  input  1  command: begin a new count from IDLE, or resume from PAUSE
- Stop  input  1  command: pause from RUN, or abort from PAUSE
- Down  input  1  direction, sampled with Start from IDLE (0 = up, 1 = down)
- Limit  input  WIDTH  terminal value, sampled with Start from IDLE
- T  output  WIDTH  toggle enables applied at the coming edge (combinational from state/Count)
- Count  output  WIDTH  current toggle-bank value (registered)
- Busy  output  1  high in RUN or PAUSE (registered state decode)
- Done  output  1  one-cycle completion pulse, high only in DONE

## Operation
- States: IDLE, RUN, PAUSE, DONE. Encoding is free; decodes must be glitch-free registered state bits.
- IDLE:
  - Start=1 and Stop=0: latch Down into dir_r and Limit into lim_r. Load Count with 0 (up) or Limit (down). Go to RUN. This load is direct; T=0 on that edge.
  - Otherwise hold. Count keeps its last value.
- RUN:
  - Terminal value is lim_r (up) or 0 (down).
  - Count == terminal: T=0, next state DONE.
  - Stop=1 (checked only when not at terminal): T=0, next state PAUSE, Count held.
  - Otherwise apply the toggle mask and set Count <= Count ^ T:
    - Up: T[0]=1, T[i]=&Count[i-1:0].
    - Down: T[0]=1, T[i]=&(~Count[i-1:0]).
- PAUSE: T=0.
  - Stop=1: go to IDLE (abort). Stop wins over Start. No Done pulse.
  - Start=1 and Stop=0: go to RUN. dir_r and lim_r are unchanged; new Down/Limit are ignored.
- DONE: T=0, Done=1, unconditionally return to IDLE next edge. Start/Stop ignored.
- Start and Stop together in IDLE: ignored (Stop wins). In RUN: Stop is honoured unless Count is already at terminal.
- T is nonzero only in RUN when not at terminal. Count never wraps: the terminal check precedes any toggle.
- Limit=0 in up mode, or down mode with any Limit, reaching 0: the count completes without wrapping. Up with Limit=0 goes Start → RUN(Count=0) → DONE.
- Mid-run Reset: asynchronous return to IDLE; all outputs go to reset values within the same cycle.

## Timing
- Reset values: state=IDLE, Count=0, dir_r=0, lim_r=0, Busy=0, Done=0, T=0.
- Start sampled at edge E0: Count=start value and Busy=1 after E0.
- Up with Limit=L, no pause:
  - Count reaches k after edge E0+k, for k=1..L.
  - DONE is entered at edge E0+L+1, so Done is high in cycle E0+L+1.
  - IDLE is re-entered (Busy=0, Done=0) at edge E0+L+2.
  - Total: Start-to-Done = L+1 edges.
- Down with Limit=L: symmetric, Count=L-k after edge E0+k, Done after E0+L+1.
- Each pause cycle adds exactly one edge to the total latency.
- Busy falls at the same edge DONE is entered.

## Test plan
- Reset mid-RUN:
  - Stimulus: Reset=1 asserted between clock edges while Count=5 in RUN.
  - Required: Count=0, Busy=0, T=0 immediately, before the next edge. Stays IDLE after release until Start.
- Up count, WIDTH=4:
  - Stimulus: Start, Down=0, Limit=9.
  - Required: Count steps 0..9 on consecutive edges, with T=4'b0001,0011,0001,0111,...,0001. Done pulses exactly once, 10 edges after Start. Count holds 9 in IDLE.
- Down count, WIDTH=4:
  - Stimulus: Start, Down=1, Limit=15.
  - Required: Count steps 15..0. First T=4'b0001. T=4'b1111 on 8→7. Done once 16 edges after Start. No wrap to 15.
- Pause/resume:
  - Stimulus: up, Limit=6. Stop at Count=3 for 3 cycles, then Start with Limit=1, Down=1 applied.
  - Required: Count frozen at 3 with T=0 during the pause. Resumes as up count to 6. Done at Start+7+3 edges.
- Abort and conflicts:
  - Stimulus: Start and Stop together in IDLE; then Stop in PAUSE.
  - Required: the simultaneous command stays in IDLE. Stop in PAUSE returns to IDLE with no Done pulse.
- Limit=0, up mode:
  - Stimulus: Start, Down=0, Limit=0.
  - Required: RUN for one cycle with T=0, Done one edge later, Count stays 0.
